// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, time limits and minute/second increment helper
package alarm_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RING = 2'd2, SNOOZE = 2'd3} state_t;
   localparam logic [5:0] MAX_MS = 6'd59;
   function automatic logic [5:0] inc_ms(input logic [5:0] v);
      return (v == MAX_MS) ? 6'd0 : v + 6'd1;
   endfunction
endpackage

// File: rtl/alarm_if.sv
// alarm_if: alarm unit signal bundle
//   master drives time, tick, enable and button pulses; slave returns alarm time, ringing and buzz
interface alarm_if;
   logic       i_tick_1hz;
   logic [5:0] i_sec;
   logic [5:0] i_min;
   logic       i_alarm_en;
   logic       i_inc_min;
   logic       i_inc_sec;
   logic       i_stop;
   logic       i_snooze;
   logic [5:0] o_alarm_min;
   logic [5:0] o_alarm_sec;
   logic       o_ringing;
   logic       o_buzz;
   modport master (output i_tick_1hz, i_sec, i_min, i_alarm_en, i_inc_min, i_inc_sec, i_stop, i_snooze,
                   input o_alarm_min, o_alarm_sec, o_ringing, o_buzz);
   modport slave (input i_tick_1hz, i_sec, i_min, i_alarm_en, i_inc_min, i_inc_sec, i_stop, i_snooze,
                  output o_alarm_min, o_alarm_sec, o_ringing, o_buzz);
endinterface

// File: rtl/tone_gen.sv
// tone_gen: square wave at TONE_HZ while i_en is high, held at 0 otherwise
//   clk, rst (async, active high), i_en enable, o_tone registered tone output
module tone_gen #(
   parameter int CLK_HZ  = 50000000,
   parameter int TONE_HZ = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_tone
);
   localparam int HALF = CLK_HZ / (2 * TONE_HZ);
   localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
   logic [TW-1:0] r_tone_cnt;
   logic          r_tone_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tone_cnt <= '0;
         r_tone_q   <= 1'b0;
      end else if (!i_en) begin
         r_tone_cnt <= '0;
         r_tone_q   <= 1'b0;
      end else if (r_tone_cnt == TW'(HALF - 1)) begin
         r_tone_cnt <= '0;
         r_tone_q   <= ~r_tone_q;
      end else begin
         r_tone_cnt <= r_tone_cnt + 1'b1;
      end
   end
   assign o_tone = r_tone_q;
endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: alarm time store, match detection, ring/snooze FSM and buzzer gating
//   clk, rst (async, active high); bus (alarm_if.slave) carries time, tick, enable, buttons and outputs
//   optional snooze support is built when ALARM_SNOOZE_EN is defined
module alarm_unit import alarm_pkg::*; #(
   parameter int CLK_HZ     = 50000000,
   parameter int TONE_HZ    = 1000,
   parameter int RING_SEC   = 30,
   parameter int SNOOZE_SEC = 60
) (
   input logic   clk,
   input logic   rst,
   alarm_if.slave bus
);
   localparam int RW = $clog2(RING_SEC + 1);
   state_t        r_state, w_next;
   logic          r_match_q, r_ringing, w_match, w_trig, w_edit, w_buzz;
   logic [5:0]    r_alarm_min, r_alarm_sec;
   logic [RW-1:0] r_ring_cnt, w_ring_cnt;
`ifdef ALARM_SNOOZE_EN
   localparam int SW = $clog2(SNOOZE_SEC + 1);
   logic [SW-1:0] r_snz_cnt, w_snz_cnt;
`else
   logic          w_unused_snooze;
   assign w_unused_snooze = bus.i_snooze;
`endif
   assign w_match = (bus.i_min == r_alarm_min) && (bus.i_sec == r_alarm_sec);
   // only the rising edge of match fires, so a held time cannot re-trigger
   assign w_trig  = w_match && !r_match_q;
   assign w_edit  = (r_state == IDLE) || (r_state == ARMED);
   always_comb begin
      w_next     = r_state;
      w_ring_cnt = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
      w_snz_cnt  = r_snz_cnt;
`endif
      case (r_state)
         IDLE: w_next = bus.i_alarm_en ? ARMED : IDLE;
         ARMED: begin
            if (!bus.i_alarm_en) w_next = IDLE;
            else if (w_trig) begin
               w_next     = RING;
               w_ring_cnt = RW'(RING_SEC);
            end
         end
         RING: begin
            if (!bus.i_alarm_en) w_next = IDLE;
            else if (bus.i_stop) w_next = ARMED;
`ifdef ALARM_SNOOZE_EN
            else if (bus.i_snooze) begin
               w_next    = SNOOZE;
               w_snz_cnt = SW'(SNOOZE_SEC);
            end
`endif
            else if (bus.i_tick_1hz) begin
               w_ring_cnt = r_ring_cnt - RW'(1);
               if (r_ring_cnt == RW'(1)) w_next = ARMED;
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (!bus.i_alarm_en) w_next = IDLE;
            else if (bus.i_stop) w_next = ARMED;
            else if (bus.i_tick_1hz) begin
               w_snz_cnt = r_snz_cnt - SW'(1);
               if (r_snz_cnt == SW'(1)) begin
                  w_next     = RING;
                  w_ring_cnt = RW'(RING_SEC);
               end
            end
         end
`endif
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_match_q   <= 1'b1;
         r_ringing   <= 1'b0;
         r_alarm_min <= '0;
         r_alarm_sec <= '0;
         r_ring_cnt  <= '0;
`ifdef ALARM_SNOOZE_EN
         r_snz_cnt   <= '0;
`endif
      end else begin
         r_state     <= w_next;
         r_match_q   <= w_match;
         r_ringing   <= (w_next == RING);
         r_alarm_min <= (w_edit && bus.i_inc_min) ? inc_ms(r_alarm_min) : r_alarm_min;
         r_alarm_sec <= (w_edit && bus.i_inc_sec) ? inc_ms(r_alarm_sec) : r_alarm_sec;
         r_ring_cnt  <= w_ring_cnt;
`ifdef ALARM_SNOOZE_EN
         r_snz_cnt   <= w_snz_cnt;
`endif
      end
   end
   // enabled from the next state so the tone clears on the same edge that leaves RING
   tone_gen #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ)) u_tone (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_next == RING),
      .o_tone (w_buzz)
   );
   assign bus.o_alarm_min = r_alarm_min;
   assign bus.o_alarm_sec = r_alarm_sec;
   assign bus.o_ringing   = r_ringing;
   assign bus.o_buzz      = w_buzz;
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed checks of arming, triggering, tone, stop/snooze, editing and reset
module tb_alarm_unit;
   import alarm_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   alarm_if bus ();
   alarm_unit #(.CLK_HZ(1000), .TONE_HZ(100), .RING_SEC(3), .SNOOZE_SEC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic pulse_tick();
      bus.i_tick_1hz = 1'b1;
      step(1);
      bus.i_tick_1hz = 1'b0;
      step(1);
   endtask
   task automatic retrigger();
      bus.i_sec = 6'd4;
      step(1);
      bus.i_sec = 6'd5;
      step(1);
   endtask
   initial begin
      bus.i_tick_1hz = 0; bus.i_sec = 0; bus.i_min = 0; bus.i_alarm_en = 0;
      bus.i_inc_min = 0; bus.i_inc_sec = 0; bus.i_stop = 0; bus.i_snooze = 0;
      step(2);
      check("rst_ring", int'(bus.o_ringing), 0);
      check("rst_buzz", int'(bus.o_buzz), 0);
      check("rst_amin", int'(bus.o_alarm_min), 0);
      check("rst_asec", int'(bus.o_alarm_sec), 0);
      check("rst_state", int'(dut.r_state), int'(IDLE));
      rst = 1'b0;
      bus.i_alarm_en = 1'b1;
      step(1);
      check("arm_state", int'(dut.r_state), int'(ARMED));
      step(3);
      check("arm_noring", int'(bus.o_ringing), 0);
      check("arm_state2", int'(dut.r_state), int'(ARMED));
      bus.i_inc_sec = 1'b1;
      step(5);
      bus.i_inc_sec = 1'b0;
      check("set_sec5", int'(bus.o_alarm_sec), 5);
      check("set_noring", int'(bus.o_ringing), 0);
      retrigger();
      check("trig_ring", int'(bus.o_ringing), 1);
      check("trig_buzz0", int'(bus.o_buzz), 0);
      step(3);
      check("buzz_low4", int'(bus.o_buzz), 0);
      step(1);
      check("buzz_rise", int'(bus.o_buzz), 1);
      step(4);
      check("buzz_high", int'(bus.o_buzz), 1);
      step(1);
      check("buzz_fall", int'(bus.o_buzz), 0);
      pulse_tick();
      pulse_tick();
      check("tick2_ring", int'(bus.o_ringing), 1);
      bus.i_tick_1hz = 1'b1;
      step(1);
      bus.i_tick_1hz = 1'b0;
      check("auto_ring", int'(bus.o_ringing), 0);
      check("auto_buzz", int'(bus.o_buzz), 0);
      check("auto_state", int'(dut.r_state), int'(ARMED));
      step(3);
      check("held_noretrig", int'(bus.o_ringing), 0);
      retrigger();
      check("trig2_ring", int'(bus.o_ringing), 1);
      bus.i_stop = 1'b1; bus.i_snooze = 1'b1;
      step(1);
      bus.i_stop = 1'b0; bus.i_snooze = 1'b0;
      check("stopsnz_ring", int'(bus.o_ringing), 0);
      check("stopsnz_state", int'(dut.r_state), int'(ARMED));
      step(3);
      check("stop_noretrig", int'(bus.o_ringing), 0);
      retrigger();
      check("trig3_ring", int'(bus.o_ringing), 1);
      bus.i_snooze = 1'b1;
      step(1);
      bus.i_snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
      check("snz_state", int'(dut.r_state), int'(SNOOZE));
      check("snz_ring", int'(bus.o_ringing), 0);
      check("snz_buzz", int'(bus.o_buzz), 0);
      pulse_tick();
      check("snz_tick1", int'(dut.r_state), int'(SNOOZE));
      pulse_tick();
      check("snz_rering", int'(bus.o_ringing), 1);
`else
      check("nosnz_state", int'(dut.r_state), int'(RING));
      check("nosnz_ring", int'(bus.o_ringing), 1);
`endif
      bus.i_stop = 1'b1;
      step(1);
      bus.i_stop = 1'b0;
      check("stop_ring", int'(bus.o_ringing), 0);
      bus.i_inc_min = 1'b1;
      step(1);
      bus.i_inc_min = 1'b0;
      check("min1", int'(bus.o_alarm_min), 1);
      bus.i_inc_sec = 1'b1;
      step(54);
      bus.i_inc_sec = 1'b0;
      check("sec59", int'(bus.o_alarm_sec), 59);
      bus.i_inc_sec = 1'b1;
      step(1);
      bus.i_inc_sec = 1'b0;
      check("sec_wrap", int'(bus.o_alarm_sec), 0);
      check("wrap_min", int'(bus.o_alarm_min), 1);
      bus.i_inc_min = 1'b1; bus.i_inc_sec = 1'b1;
      step(1);
      bus.i_inc_min = 1'b0; bus.i_inc_sec = 1'b0;
      check("both_min", int'(bus.o_alarm_min), 2);
      check("both_sec", int'(bus.o_alarm_sec), 1);
      bus.i_min = 6'd2; bus.i_sec = 6'd1;
      step(1);
      check("trig4_ring", int'(bus.o_ringing), 1);
      bus.i_inc_min = 1'b1; bus.i_inc_sec = 1'b1;
      step(1);
      bus.i_inc_min = 1'b0; bus.i_inc_sec = 1'b0;
      check("ring_min_keep", int'(bus.o_alarm_min), 2);
      check("ring_sec_keep", int'(bus.o_alarm_sec), 1);
      step(4);
      check("pre_rst_buzz", int'(bus.o_buzz), 1);
      rst = 1'b1;
      #1;
      check("arst_ring", int'(bus.o_ringing), 0);
      check("arst_buzz", int'(bus.o_buzz), 0);
      check("arst_amin", int'(bus.o_alarm_min), 0);
      check("arst_asec", int'(bus.o_alarm_sec), 0);
      check("arst_state", int'(dut.r_state), int'(IDLE));
      step(1);
      rst = 1'b0;
      bus.i_alarm_en = 1'b0;
      step(2);
      check("dis_state", int'(dut.r_state), int'(IDLE));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
